single_argmin_stream: RTL and testbench

- Streaming reduction stage that consumes a frame of IEEE-754 single-precision words and returns the minimum value and its index.
- Sits downstream of the pairwise single-precision min comparator in the precision datapath.
- Applies the same sign/exponent/mantissa ordering every cycle against a registered running minimum.
- Emits one result per frame over a valid/ready handshake.

---
 rtl/single_argmin_stream_if.sv | 26 ++
 rtl/single_argmin_stream.sv | 136 +++++++++++++
 tb/tb_single_argmin_stream.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/single_argmin_stream_if.sv
// Stream-side bundle for single_argmin_stream: element input and frame-result output.
// The slave modport is the reduction block; the master modport is whoever drives it.
interface single_argmin_stream_if #(
  parameter int IDX_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_min;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W-1:0] out_count;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_idx, out_count, out_ovf
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_idx, out_count, out_ovf
  );
endinterface

// File: rtl/single_argmin_stream.sv
// Frame-wise argmin over IEEE-754 single words using total sign/magnitude bit ordering.
// One result per frame, presented one cycle after the last element is accepted.
module single_argmin_stream #(
  parameter int IDX_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  single_argmin_stream_if.slave s
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [31:0]      min_q, min_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_min_q, out_min_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [IDX_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic accept;
  logic cand_less;

  // Strict a < b; equal words are never less, so the earliest index survives ties.
  function automatic logic fp_less(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31];
    else if (!a[31])    return a[30:0] < b[30:0];
    else                return a[30:0] > b[30:0];
  endfunction

  assign s.in_ready = (state_q != ST_HOLD);
  assign accept     = s.in_valid && s.in_ready;
  assign cand_less  = fp_less(s.in_data, min_q);

  always_comb begin
    // NOTE: every next-state signal gets a default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    min_d       = min_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_min_d   = out_min_q;
    out_idx_d   = out_idx_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          min_d   = s.in_data;
          idx_d   = '0;
          cnt_d   = IDX_W'(1);
          ovf_d   = 1'b0;
          state_d = s.in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          if (cand_less) begin
            min_d = s.in_data;
            idx_d = cnt_q;
          end
          cnt_d = cnt_q + 1'b1;
          // A wrap only counts as overflow if more elements follow it.
          if (cnt_q == CNT_MAX && !s.in_last) ovf_d = 1'b1;
          state_d = s.in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && s.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          min_d       = '0;
          idx_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Result registers capture the running state including the closing element.
    if (accept && s.in_last) begin
      out_valid_d = 1'b1;
      out_min_d   = min_d;
      out_idx_d   = idx_d;
      out_count_d = cnt_d;
      out_ovf_d   = ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q     <= ST_IDLE;
      min_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_min_q   <= '0;
      out_idx_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_min_q   <= out_min_d;
      out_idx_q   <= out_idx_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.out_min   = out_min_q;
  assign s.out_idx   = out_idx_q;
  assign s.out_count = out_count_q;
  assign s.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_single_argmin_stream.sv
// Directed bench: table of frames on a 16-bit-index instance, plus backpressure,
// mid-frame reset and counter-wrap sequences (the latter on a 2-bit-index instance).
module tb_single_argmin_stream;

  logic clk;
  logic rstn;

  single_argmin_stream_if #(.IDX_W(16)) a ();
  single_argmin_stream_if #(.IDX_W(2))  b ();

  single_argmin_stream #(.IDX_W(16)) u_dut16 (.clk(clk), .rstn(rstn), .s(a));
  single_argmin_stream #(.IDX_W(2))  u_dut2  (.clk(clk), .rstn(rstn), .s(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] d0, d1, d2, d3;
    int          len;
    logic [31:0] e_min;
    int          e_idx;
    int          e_cnt;
    logic        e_ovf;
    int          hold;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input int len, input logic [31:0] e_min,
                              input int e_idx, input int e_cnt, input int hold);
    vec_t v;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.len = len; v.e_min = e_min; v.e_idx = e_idx; v.e_cnt = e_cnt;
    v.e_ovf = 1'b0; v.hold = hold;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_a(input logic [31:0] d, input logic last);
    a.in_valid = 1'b1; a.in_data = d; a.in_last = last;
    @(negedge clk);
    a.in_valid = 1'b0; a.in_last = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic last);
    b.in_valid = 1'b1; b.in_data = d; b.in_last = last;
    @(negedge clk);
    b.in_valid = 1'b0; b.in_last = 1'b0;
  endtask

  // Called on the negedge right after the closing accept.
  task automatic result_a(input string tag, input logic [31:0] em, input int ei,
                          input int ec, input logic eo, input int hold);
    check({tag, "_valid"}, 32'(a.out_valid), 32'd1);
    check({tag, "_min"},   a.out_min, em);
    check({tag, "_idx"},   32'(a.out_idx), 32'(ei));
    check({tag, "_cnt"},   32'(a.out_count), 32'(ec));
    check({tag, "_ovf"},   32'(a.out_ovf), 32'(eo));
    check({tag, "_rdy0"},  32'(a.in_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      a.in_valid = 1'b1; a.in_data = 32'hFF800000; a.in_last = 1'b1;
      @(negedge clk);
      check($sformatf("%s_hold%0d_rdy", tag, k), 32'(a.in_ready), 32'd0);
      check($sformatf("%s_hold%0d_vld", tag, k), 32'(a.out_valid), 32'd1);
      check($sformatf("%s_hold%0d_min", tag, k), a.out_min, em);
      check($sformatf("%s_hold%0d_idx", tag, k), 32'(a.out_idx), 32'(ei));
      check($sformatf("%s_hold%0d_cnt", tag, k), 32'(a.out_count), 32'(ec));
    end
    a.in_valid = 1'b0; a.in_last = 1'b0;
    a.out_ready = 1'b1;
    @(negedge clk);
    a.out_ready = 1'b0;
    check({tag, "_drop"},     32'(a.out_valid), 32'd0);
    check({tag, "_rdy1"},     32'(a.in_ready), 32'd1);
    check({tag, "_keep_min"}, a.out_min, em);
  endtask

  task automatic result_b(input string tag, input logic [31:0] em, input int ei,
                          input int ec, input logic eo);
    check({tag, "_valid"}, 32'(b.out_valid), 32'd1);
    check({tag, "_min"},   b.out_min, em);
    check({tag, "_idx"},   32'(b.out_idx), 32'(ei));
    check({tag, "_cnt"},   32'(b.out_count), 32'(ec));
    check({tag, "_ovf"},   32'(b.out_ovf), 32'(eo));
    b.out_ready = 1'b1;
    @(negedge clk);
    b.out_ready = 1'b0;
    check({tag, "_drop"}, 32'(b.out_valid), 32'd0);
    check({tag, "_rdy1"}, 32'(b.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(32'h3F800000, 32'hC0000000, 32'h3F000000, 32'h0, 3, 32'hC0000000, 1, 3, 0);
    vecs[1] = mk(32'h3F000000, 32'h3F000000, 32'h0, 32'h0,        2, 32'h3F000000, 0, 2, 0);
    vecs[2] = mk(32'h00000000, 32'h80000000, 32'h0, 32'h0,        2, 32'h80000000, 1, 2, 0);
    vecs[3] = mk(32'hBF000000, 32'hC0000000, 32'h0, 32'h0,        2, 32'hC0000000, 1, 2, 0);
    vecs[4] = mk(32'h40400000, 32'h0, 32'h0, 32'h0,               1, 32'h40400000, 0, 1, 5);
    vecs[5] = mk(32'h3F800000, 32'h0, 32'h0, 32'h0,               1, 32'h3F800000, 0, 1, 0);
    vecs[6] = mk(32'h7F800000, 32'hFF800000, 32'h80000000, 32'h00000001,
                 4, 32'hFF800000, 1, 4, 0);
    vecs[7] = mk(32'hC0000000, 32'hBF800000, 32'hC0400000, 32'hC0400000,
                 4, 32'hC0400000, 2, 4, 0);

    rstn = 1'b0;
    a.in_valid = 1'b0; a.in_data = '0; a.in_last = 1'b0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.in_last = 1'b0; b.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    check("rst_rdy",   32'(a.in_ready), 32'd1);
    check("rst_valid", 32'(a.out_valid), 32'd0);
    check("rst_min",   a.out_min, 32'd0);
    check("rst_idx",   32'(a.out_idx), 32'd0);
    check("rst_cnt",   32'(a.out_count), 32'd0);
    check("rst_ovf",   32'(a.out_ovf), 32'd0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] d [4];
      d[0] = vecs[i].d0; d[1] = vecs[i].d1; d[2] = vecs[i].d2; d[3] = vecs[i].d3;
      for (int j = 0; j < vecs[i].len; j++) begin
        send_a(d[j], j == vecs[i].len - 1);
        if (j < vecs[i].len - 1)
          check($sformatf("f%0d_e%0d_novld", i, j), 32'(a.out_valid), 32'd0);
      end
      result_a($sformatf("f%0d", i), vecs[i].e_min, vecs[i].e_idx,
               vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].hold);
    end

    // Reset in the middle of a frame discards it.
    send_a(32'h3F800000, 1'b0);
    send_a(32'h40000000, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mrst_novld%0d", k), 32'(a.out_valid), 32'd0);
      check($sformatf("mrst_rdy%0d", k), 32'(a.in_ready), 32'd1);
      @(negedge clk);
    end
    check("mrst_min_cleared", a.out_min, 32'd0);
    send_a(32'h3F800000, 1'b0);
    send_a(32'hBF800000, 1'b1);
    result_a("postrst", 32'hBF800000, 1, 2, 1'b0, 0);

    // Five elements through a 2-bit counter: wrap, sticky overflow.
    for (int j = 0; j < 4; j++) send_b(32'h40400000, 1'b0);
    send_b(32'h3F000000, 1'b1);
    result_b("ovf", 32'h3F000000, 0, 1, 1'b1);

    // Exactly four elements: count wraps to 0 but no overflow; idle gap mid-frame.
    send_b(32'h3F800000, 1'b0);
    send_b(32'h3F000000, 1'b0);
    repeat (3) @(negedge clk);
    check("gap_novld", 32'(b.out_valid), 32'd0);
    send_b(32'h40000000, 1'b0);
    send_b(32'h3F000000, 1'b1);
    result_b("full4", 32'h3F000000, 1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
